fetch_unit: RTL and testbench

Parametrised, decoupled instruction-fetch front end for the RV32 core. It generates sequential fetch addresses, issues reads to a fixed one-cycle-latency instruction memory, and buffers returned words with their PCs in a DEPTH-entry FIFO. The FIFO feeds decode through a valid/ready handshake. Branch and jump redirects from the execute stage flush the buffer and restart fetch at a new PC, which lets decode stall without losing instructions.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled RV32 instruction-fetch front end.
// Issues sequential word-aligned reads to a one-cycle-latency instruction memory and
// buffers returned {pc, instr} pairs in a DEPTH-entry circular FIFO that feeds decode
// through a valid/ready handshake. A redirect flushes the buffer and restarts fetch.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [WIDTH-1:0]       imem_addr,
    input  logic [WIDTH-1:0]       imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_instr,
    output logic [WIDTH-1:0]       out_pc,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Reset PC with the byte-offset bits forced to zero so fetch_pc is always aligned.
    localparam logic [WIDTH-1:0] ResetPcAligned = {RESET_PC[WIDTH-1:2], 2'b00};

    // Fetch address generator and single outstanding request tracking.
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    // FIFO bookkeeping.
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // FIFO storage; contents need no reset since count gates visibility.
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic             pop;
    logic             push;
    logic [CntW:0]    occupancy;
    logic             space;

    // Low address bits of a redirect target are dropped on purpose.
    logic [1:0]       unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirect_pc[1:0];

    // Handshake, space check and output drive.
    always_comb begin
        out_valid = (count_q != '0) && !redirect;
        pop       = out_valid && out_ready;

        // Slots already claimed once this cycle's pop is accounted for. Counting the pop
        // keeps a two-entry FIFO streaming at one instruction per cycle.
        occupancy = {1'b0, count_q}
                  + {{CntW{1'b0}}, inflight_q}
                  - {{CntW{1'b0}}, pop};
        space     = occupancy < (CntW + 1)'(DEPTH);

        // Gating with rst keeps the request low while reset is held.
        imem_req  = rst && !redirect && space;
        imem_addr = fetch_pc_q;

        out_pc    = pc_mem[rd_ptr_q];
        out_instr = instr_mem[rd_ptr_q];
        count     = count_q;
    end

    // Next-state: redirect overrides request, push and pop in the same cycle.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        push          = 1'b0;

        if (redirect) begin
            // Flush; any response returning this cycle is simply not pushed.
            fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_d    = fetch_pc_q + WIDTH'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end

            // The space check at request time guarantees this push fits.
            push = inflight_q;

            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= ResetPcAligned;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO entry write on response arrival.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by random traffic on a DEPTH=4 and a DEPTH=2
// instance, both compared every cycle against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC  = 32'h0;
    localparam logic [31:0] XORK = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req4, req2, valid4, valid2;
    logic [31:0] addr4, addr2, rdata4, rdata2, instr4, instr2, pc4, pc2;
    logic [2:0]  cnt4;
    logic [1:0]  cnt2;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: per-instance FIFO of delivered PCs, fetch PC and pending read.
    logic [31:0] m_fifo  [2][$];
    logic [31:0] m_fpc   [2];
    logic [31:0] m_ipc   [2];
    logic [31:0] m_next  [2];
    bit          m_inf   [2];
    int          m_depth [2] = '{4, 2};

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(RPC)) u_d4 (
        .clk(clk), .rst(rst), .imem_req(req4), .imem_addr(addr4), .imem_rdata(rdata4),
        .out_valid(valid4), .out_ready(out_ready), .out_instr(instr4), .out_pc(pc4),
        .redirect(redirect), .redirect_pc(redirect_pc), .count(cnt4)
    );

    fetch_unit #(.WIDTH(32), .DEPTH(2), .RESET_PC(RPC)) u_d2 (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
        .out_valid(valid2), .out_ready(out_ready), .out_instr(instr2), .out_pc(pc2),
        .redirect(redirect), .redirect_pc(redirect_pc), .count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency instruction memory: word at addr is addr ^ XORK.
    always @(posedge clk) begin
        rdata4 <= addr4 ^ XORK;
        rdata2 <= addr2 ^ XORK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_valid(input int k);
        return (rst === 1'b1) && (redirect !== 1'b1) && (m_fifo[k].size() != 0);
    endfunction

    function automatic bit exp_req(input int k);
        int claimed;
        claimed = m_fifo[k].size() + int'(m_inf[k]) - int'(exp_valid(k) && out_ready);
        return (rst === 1'b1) && (redirect !== 1'b1) && (claimed < m_depth[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_fifo[k].delete();
            m_fpc[k]  = RPC;
            m_ipc[k]  = '0;
            m_next[k] = RPC;
            m_inf[k]  = 1'b0;
        end
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit pop;
            bit req;
            pop = exp_valid(k) && out_ready;
            req = exp_req(k);
            if (rst === 1'b1) begin
                if (redirect) begin
                    m_fifo[k].delete();
                    m_inf[k]  = 1'b0;
                    m_fpc[k]  = redirect_pc & ~32'h3;
                    m_next[k] = m_fpc[k];
                end else begin
                    if (pop) begin
                        void'(m_fifo[k].pop_front());
                        m_next[k] = m_next[k] + 32'd4;
                    end
                    if (m_inf[k]) m_fifo[k].push_back(m_ipc[k]);
                    if (req) begin
                        m_ipc[k] = m_fpc[k];
                        m_fpc[k] = m_fpc[k] + 32'd4;
                        m_inf[k] = 1'b1;
                    end else begin
                        m_inf[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic        o_req, o_valid;
            logic [31:0] o_addr, o_pc, o_instr, o_cnt;
            string       n;
            bit          ev;
            if (k == 0) begin
                o_req = req4; o_valid = valid4; o_addr = addr4; o_pc = pc4;
                o_instr = instr4; o_cnt = 32'(cnt4); n = "d4";
            end else begin
                o_req = req2; o_valid = valid2; o_addr = addr2; o_pc = pc2;
                o_instr = instr2; o_cnt = 32'(cnt2); n = "d2";
            end
            ev = exp_valid(k);
            check({n, " imem_req"}, 32'(o_req), 32'(exp_req(k)));
            if (exp_req(k)) check({n, " imem_addr"}, o_addr, m_fpc[k]);
            check({n, " out_valid"}, 32'(o_valid), 32'(ev));
            if (ev) begin
                check({n, " out_pc"}, o_pc, m_fifo[k][0]);
                check({n, " out_instr"}, o_instr, m_fifo[k][0] ^ XORK);
                if (out_ready) check({n, " pc_order"}, o_pc, m_next[k]);
            end
            check({n, " count"}, o_cnt, 32'(m_fifo[k].size()));
        end
    endtask

    // Called at a falling edge: apply inputs and compare the settled outputs.
    task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc);
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        compare_all();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Cycles 0..5 after reset release with out_ready high.
    task automatic startup_checks(input string s);
        drive(1'b1, 1'b0, '0);
        check({s, " c0 req"}, 32'(req4), 32'd1);
        check({s, " c0 addr"}, addr4, RPC);
        check({s, " c0 req d2"}, 32'(req2), 32'd1);
        tick();
        drive(1'b1, 1'b0, '0);
        check({s, " c1 valid"}, 32'(valid4), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, '0);
            check({s, " stream valid"}, 32'(valid4), 32'd1);
            check({s, " stream pc"}, pc4, 32'(i * 4));
            check({s, " stream pc d2"}, pc2, 32'(i * 4));
            tick();
        end
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset req", 32'(req4), 32'd0);
        check("reset valid", 32'(valid4), 32'd0);
        check("reset count", 32'(cnt4), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First fetch and streaming; DEPTH=2 must not bubble.
        startup_checks("start");
        for (int c = 6; c < 19; c++) begin
            drive(1'b1, 1'b0, '0);
            check("d2 stream count<=1", 32'(cnt2 <= 2'd1), 32'd1);
            tick();
        end
        drive(1'b1, 1'b0, '0);
        check("d2 c19 valid", 32'(valid2), 32'd1);
        check("d2 c19 pc", pc2, 32'h44);
        tick();

        // Backpressure from cycle 3 for 10 cycles.
        do_reset();
        for (int c = 0; c < 23; c++) begin
            drive((c < 3 || c > 12) ? 1'b1 : 1'b0, 1'b0, '0);
            if (c == 12) begin
                check("stall count d4", 32'(cnt4), 32'd4);
                check("stall req d4", 32'(req4), 32'd0);
                check("stall count d2", 32'(cnt2), 32'd2);
                check("stall req d2", 32'(req2), 32'd0);
            end
            if (c == 13) begin
                check("release pc d4", pc4, 32'h4);
                check("release pc d2", pc2, 32'h4);
            end
            tick();
        end

        // Redirect to 0x102 with count=3 and a response in flight (DEPTH=4).
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h102);
        check("redir pre count", 32'(cnt4), 32'd3);
        check("redir valid", 32'(valid4), 32'd0);
        check("redir req", 32'(req4), 32'd0);
        tick();
        drive(1'b1, 1'b0, '0);
        check("redir R+1 req", 32'(req4), 32'd1);
        check("redir R+1 addr", addr4, 32'h100);
        tick();
        drive(1'b1, 1'b0, '0);
        check("redir R+2 valid", 32'(valid4), 32'd0);
        tick();
        drive(1'b1, 1'b0, '0);
        check("redir R+3 valid", 32'(valid4), 32'd1);
        check("redir R+3 pc", pc4, 32'h100);
        tick();

        // Address wrap-around.
        drive(1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        repeat (2) begin
            drive(1'b1, 1'b0, '0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, '0);
            check("wrap valid", 32'(valid4), 32'd1);
            check("wrap pc", pc4, 32'hFFFF_FFF8 + 32'(i * 4));
            tick();
        end

        // Asynchronous reset between edges with count=3.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1'b0, 1'b0, '0);
            if (cnt4 == 3'd3) found = 1'b1;
            else tick();
        end
        check("midrst setup count", 32'(cnt4), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("midrst valid", 32'(valid4), 32'd0);
        check("midrst req", 32'(req4), 32'd0);
        check("midrst count", 32'(cnt4), 32'd0);
        check("midrst count d2", 32'(cnt2), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        startup_checks("restart");

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : $urandom;
            drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, rpc);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
